// File: rtl/hazard_pkg.sv
// Shared operand-select encodings and default timing parameters for the
// pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSelT;

  localparam int LOAD_BUBBLES_DEF = 1;
  localparam int MD_LAT_DEF       = 4;

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single in-flight MUL/DIV op: destination busy bit and a latency
// countdown that runs regardless of pipeline stalls.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdIssue,
  input  logic            freeze,
  input  logic [RAW-1:0]  issueRd,
  output logic [NREG-1:0] busy,
  output logic            mdBusy,
  output logic            mdDone
);

  logic [CNT_W-1:0] mdCnt;
  logic [RAW-1:0]   mdRd;
  logic             issueOk;

  assign mdBusy  = (mdCnt != '0);
  assign mdDone  = (mdCnt == CNT_W'(1));
  // A second op waiting in E is held off until the unit has fully drained.
  assign issueOk = mdIssue && (issueRd != '0) && !freeze && !mdBusy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdCnt <= '0;
      mdRd  <= '0;
      busy  <= '0;
    end else if (issueOk) begin
      mdCnt         <= CNT_W'(MD_LAT);
      mdRd          <= issueRd;
      busy[issueRd] <= 1'b1;
    end else begin
      if (mdBusy) mdCnt <= mdCnt - CNT_W'(1);
      if (mdDone) busy[mdRd] <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use bubbles,
// MUL/DIV scoreboard stalls, memory-wait freeze and branch flush.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG         = 32,
  parameter int RAW          = 5,
  parameter int LOAD_BUBBLES = LOAD_BUBBLES_DEF,
  parameter int MD_LAT       = MD_LAT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RegWriteM,
  input  logic           RegWriteW,
  input  logic [RAW-1:0] RD_E,
  input  logic [RAW-1:0] RD_M,
  input  logic [RAW-1:0] RD_W,
  input  logic [RAW-1:0] Rs1_D,
  input  logic [RAW-1:0] Rs2_D,
  input  logic [RAW-1:0] Rs1_E,
  input  logic [RAW-1:0] Rs2_E,
  input  logic           ResultSrcE,
  input  logic           MdIssueE,
  input  logic           MemReadyM,
  input  logic           PCSrcE,
  output logic [1:0]     ForwardAE,
  output logic [1:0]     ForwardBE,
  output logic           StallF,
  output logic           StallD,
  output logic           StallE,
  output logic           StallM,
  output logic           FlushD,
  output logic           FlushE,
  output logic           MdBusy,
  output logic           MdDone
);

  logic             freeze;
  logic             loadUse;
  logic             rawBusy;
  logic             structStall;
  logic [CNT_W-1:0] bubbleCnt;
  logic [NREG-1:0]  busy;

  md_scoreboard #(
    .NREG  (NREG),
    .RAW   (RAW),
    .MD_LAT(MD_LAT),
    .CNT_W (CNT_W)
  ) uMdScoreboard (
    .clk    (clk),
    .rst    (rst),
    .mdIssue(MdIssueE),
    .freeze (freeze),
    .issueRd(RD_E),
    .busy   (busy),
    .mdBusy (MdBusy),
    .mdDone (MdDone)
  );

  function automatic logic [1:0] fwdSel(input logic [RAW-1:0] rs,
                                        input logic wrM, input logic [RAW-1:0] rdM,
                                        input logic wrW, input logic [RAW-1:0] rdW);
    if (rs == '0)             return FWD_RF;
    if (wrM && (rdM == rs))   return FWD_M;
    if (wrW && (rdW == rs))   return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      ForwardAE = fwdSel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
      ForwardBE = fwdSel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
    end
  end

  assign freeze      = !MemReadyM;
  assign loadUse     = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  assign rawBusy     = busy[Rs1_D] || busy[Rs2_D];
  assign structStall = MdIssueE && MdBusy;

  // Bubble count freezes with the pipeline and is discarded on a taken branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubbleCnt <= '0;
    end else if (!freeze) begin
      if (PCSrcE)                 bubbleCnt <= '0;
      else if (loadUse)           bubbleCnt <= CNT_W'(LOAD_BUBBLES - 1);
      else if (bubbleCnt != '0)   bubbleCnt <= bubbleCnt - CNT_W'(1);
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (structStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else if (loadUse || (bubbleCnt != '0) || rawBusy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with LOAD_BUBBLES=2, MD_LAT=4.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       RegWriteM, RegWriteW, ResultSrcE, MdIssueE, MemReadyM, PCSrcE;
  logic [4:0] RD_E, RD_M, RD_W, Rs1_D, Rs2_D, Rs1_E, Rs2_E;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MdBusy, MdDone;
  logic [5:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NREG(32), .RAW(5), .LOAD_BUBBLES(2), .MD_LAT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .ResultSrcE(ResultSrcE), .MdIssueE(MdIssueE), .MemReadyM(MemReadyM), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .MdBusy(MdBusy), .MdDone(MdDone)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 1'b0; MdIssueE = 1'b0;
    MemReadyM = 1'b1; PCSrcE = 1'b0;
    RD_E = '0; RD_M = '0; RD_W = '0; Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    RegWriteM = 1'b1; RD_M = 5'd5; Rs1_E = 5'd5; Rs2_E = 5'd5; MemReadyM = 1'b0; PCSrcE = 1'b1;
    #3;
    checks++;
    if ({ForwardAE, ForwardBE, ctl, MdBusy, MdDone} !== 12'b0) begin
      errors++;
      $display("FAIL reset: outputs=%b expected=%b", {ForwardAE, ForwardBE, ctl, MdBusy, MdDone}, 12'b0);
    end
    cyc();
    idle();
    rst = 1'b1;
  endtask

  task automatic test_forwarding();
    // {RegWriteM, RD_M, RegWriteW, RD_W, Rs1_E, Rs2_E, expA, expB}
    logic [25:0] v [6];
    v[0] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10};
    v[1] = {1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01};
    v[2] = {1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 2'b00};
    v[3] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    v[4] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6, 2'b01, 2'b00};
    v[5] = {1'b1, 5'd3, 1'b1, 5'd3, 5'd4, 5'd3, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      idle();
      {RegWriteM, RD_M, RegWriteW, RD_W, Rs1_E, Rs2_E} = v[i][25:4];
      #2;
      checks++;
      if ({ForwardAE, ForwardBE} !== v[i][3:0]) begin
        errors++;
        $display("FAIL fwd[%0d]: got A=%b B=%b expected A=%b B=%b", i, ForwardAE, ForwardBE, v[i][3:2], v[i][1:0]);
      end
      cyc();
    end
  endtask

  task automatic test_load_use();
    // per cycle: {ResultSrcE, RD_E, Rs1_D, Rs2_D, expected ctl}
    logic [21:0] v [5];
    v[0] = {1'b1, 5'd7, 5'd0, 5'd7, 6'b110001};
    v[1] = {1'b0, 5'd0, 5'd0, 5'd7, 6'b110001};
    v[2] = {1'b0, 5'd0, 5'd0, 5'd7, 6'b000000};
    v[3] = {1'b1, 5'd0, 5'd0, 5'd0, 6'b000000};
    v[4] = {1'b1, 5'd7, 5'd3, 5'd4, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      idle();
      {ResultSrcE, RD_E, Rs1_D, Rs2_D} = v[i][21:6];
      #2;
      checks++;
      if (ctl !== v[i][5:0]) begin
        errors++;
        $display("FAIL load_use[%0d]: ctl=%b expected=%b", i, ctl, v[i][5:0]);
      end
      cyc();
    end
  endtask

  task automatic test_scoreboard();
    logic [7:0] exp;
    idle();
    MdIssueE = 1'b1; RD_E = 5'd9;
    #2;
    checks++;
    if ({ctl, MdBusy, MdDone} !== 8'b0) begin
      errors++;
      $display("FAIL md_issue: got=%b expected=%b", {ctl, MdBusy, MdDone}, 8'b0);
    end
    cyc();
    for (int k = 1; k <= 5; k++) begin
      idle();
      Rs1_D = 5'd9;
      #2;
      exp = (k == 5) ? 8'b000000_0_0 : {6'b110001, 1'b1, (k == 4)};
      checks++;
      if ({ctl, MdBusy, MdDone} !== exp) begin
        errors++;
        $display("FAIL md_raw[%0d]: got=%b expected=%b", k, {ctl, MdBusy, MdDone}, exp);
      end
      cyc();
    end
  endtask

  task automatic test_structural();
    logic [7:0] exp;
    idle();
    MdIssueE = 1'b1; RD_E = 5'd9;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      idle();
      MdIssueE = 1'b1; RD_E = 5'd10;
      #2;
      exp = (k == 5) ? 8'b0 : {6'b111000, 1'b1, (k == 4)};
      checks++;
      if ({ctl, MdBusy, MdDone} !== exp) begin
        errors++;
        $display("FAIL struct[%0d]: got=%b expected=%b", k, {ctl, MdBusy, MdDone}, exp);
      end
      cyc();
    end
    idle();
    Rs1_D = 5'd10;
    #2;
    checks++;
    if ({ctl, MdBusy, MdDone} !== 8'b110001_1_0) begin
      errors++;
      $display("FAIL struct_second_issue: got=%b expected=%b", {ctl, MdBusy, MdDone}, 8'b110001_1_0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      idle();
    end
    #2;
    checks++;
    if ({ctl, MdBusy, MdDone} !== 8'b0) begin
      errors++;
      $display("FAIL struct_drain: got=%b expected=%b", {ctl, MdBusy, MdDone}, 8'b0);
    end
    cyc();
  endtask

  task automatic test_freeze();
    logic [5:0] exp;
    for (int k = 0; k < 6; k++) begin
      idle();
      Rs2_D = 5'd7;
      if (k == 0) begin
        ResultSrcE = 1'b1; RD_E = 5'd7;
      end
      MemReadyM = !(k >= 1 && k <= 3);
      #2;
      case (k)
        0, 4:    exp = 6'b110001;
        1, 2, 3: exp = 6'b111100;
        default: exp = 6'b000000;
      endcase
      checks++;
      if (ctl !== exp) begin
        errors++;
        $display("FAIL freeze[%0d]: ctl=%b expected=%b", k, ctl, exp);
      end
      cyc();
    end
  endtask

  task automatic test_branch();
    logic [5:0] exp;
    for (int k = 0; k < 3; k++) begin
      idle();
      Rs1_D = 5'd7;
      if (k < 2) begin
        ResultSrcE = 1'b1; RD_E = 5'd7; PCSrcE = 1'b1;
      end
      MemReadyM = (k != 0);
      #2;
      case (k)
        0:       exp = 6'b111100;
        1:       exp = 6'b000011;
        default: exp = 6'b000000;
      endcase
      checks++;
      if (ctl !== exp) begin
        errors++;
        $display("FAIL branch[%0d]: ctl=%b expected=%b", k, ctl, exp);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_op();
    idle();
    MdIssueE = 1'b1; RD_E = 5'd9;
    cyc();
    idle();
    Rs1_D = 5'd9;
    #2;
    checks++;
    if ({ctl, MdBusy, MdDone} !== 8'b110001_1_0) begin
      errors++;
      $display("FAIL rst_mid_busy: got=%b expected=%b", {ctl, MdBusy, MdDone}, 8'b110001_1_0);
    end
    cyc();
    RegWriteM = 1'b1; RD_M = 5'd5; Rs1_E = 5'd5;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE, ctl, MdBusy, MdDone} !== 12'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: outputs=%b expected=%b", {ForwardAE, ForwardBE, ctl, MdBusy, MdDone}, 12'b0);
    end
    cyc();
    idle();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      Rs1_D = 5'd9;
      #2;
      checks++;
      if ({ctl, MdBusy, MdDone} !== 8'b0) begin
        errors++;
        $display("FAIL rst_mid_after[%0d]: got=%b expected=%b", k, {ctl, MdBusy, MdDone}, 8'b0);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_structural();
    test_freeze();
    test_branch();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Adds the following to M/W forwarding:
  - load-use detection from the Execute stage, with a parametrised bubble count;
  - a per-register scoreboard for a multi-cycle MUL/DIV unit;
  - a global freeze on data-memory wait states;
  - branch flush.
- Sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

Parameters:
- NREG, 32, number of architectural registers; x0 is never hazarded.
- RAW, 5, register address width (log2 NREG).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- MD_LAT, 4, MUL/DIV result latency in cycles after issue from E; legal range 2..15.
- CNT_W, 4, width of the internal counters; must hold max(LOAD_BUBBLES, MD_LAT).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- RegWriteM, RegWriteW  in  1  register write enables in M and W
- RD_E, RD_M, RD_W  in  RAW  destination registers in E, M and W
- Rs1_D, Rs2_D, Rs1_E, Rs2_E  in  RAW  source registers in D and E
- ResultSrcE  in  1  high when the instruction in E is a load
- MdIssueE  in  1  high when E issues a MUL/DIV writing RD_E
- MemReadyM  in  1  data memory ready; low means the M access is waiting
- PCSrcE  in  1  taken branch or jump resolved in E
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W, 10 M
- StallF, StallD, StallE, StallM  out  1  hold the PC and the D/E/M pipeline registers
- FlushD, FlushE  out  1  clear the D and E pipeline registers
- MdBusy  out  1  MUL/DIV unit occupied
- MdDone  out  1  one-cycle pulse when the MUL/DIV result is available

Behaviour:
- Reset (rst=0, asynchronous):
  - bubble counter, MUL/DIV counter and scoreboard busy vector all cleared;
  - every output is 0, including ForwardAE/BE=00.
- Forwarding (combinational):
  - M has priority over W; a source of x0 never forwards.
  - ForwardAE/BE are forced to 00 while rst=0.
- Load-use:
  - Condition: ResultSrcE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D).
  - When the condition holds, bubble counter loads LOAD_BUBBLES-1.
  - StallF=StallD=FlushE=1 while the condition holds or the counter is nonzero.
  - The counter decrements each unfrozen cycle.
- Scoreboard:
  - On MdIssueE with RD_E!=0 and no freeze: busy[RD_E] is set and the MUL/DIV counter loads MD_LAT.
  - The counter decrements each cycle, including frozen cycles; the unit is independent of the pipeline.
  - When the counter reaches 1, MdDone pulses and busy is cleared on the next edge.
  - MdBusy is 1 while the counter is nonzero.
- RAW on a busy register: busy[Rs1_D] or busy[Rs2_D] gives StallF=StallD=FlushE=1.
- Structural hazard: MdIssueE while MdBusy gives StallF=StallD=StallE=1 and FlushE=0, until MdDone.
- Memory freeze:
  - MemReadyM=0 gives StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0.
  - The bubble counter holds; no other stall or flush is asserted.
- Branch (PCSrcE=1, not frozen):
  - FlushD=FlushE=1.
  - Load-use and scoreboard stalls of the squashed D instruction are suppressed (StallF=StallD=0); the bubble counter is cleared.
- Priority: reset > memory freeze > branch flush > structural stall > load-use / scoreboard stall.
- Simultaneous MdDone and a D read of the same register: the stall still applies that cycle; the instruction proceeds the next cycle via W forwarding.
- Reset mid-operation: all state is dropped; no MdDone is emitted for the aborted op.
- Latency:
  - Forwarding and stalls are same-cycle combinational.
  - Counters and busy bits update on posedge clk.

Decomposition:
- Shared package hazard_pkg holds:
  - the FWD_RF/FWD_W/FWD_M encodings (00/01/10);
  - the default LOAD_BUBBLES and MD_LAT values.
- One sub-module, md_scoreboard: busy vector, MUL/DIV counter, MdBusy and MdDone. It is instantiated once.

Test Plan:
- RegWriteM=1, RD_M=5, Rs1_E=5, RegWriteW=1, RD_W=5 -> ForwardAE=10; repeat with RD_M=0 -> ForwardAE=01; with Rs1_E=0 -> 00.
- Load with RD_E=7, Rs2_D=7, LOAD_BUBBLES=2 -> StallF/StallD/FlushE high for exactly 2 cycles, then low.
- MdIssueE with RD_E=9, MD_LAT=4; Rs1_D=9 next cycle -> stall for 4 cycles, MdDone pulses on cycle 4, MdBusy falls after it.
- Second MdIssueE while busy -> StallE=1 and FlushE=0 until MdDone; the second op then issues.
- MemReadyM=0 for 3 cycles during an active load-use bubble -> all four stalls =1, flushes =0, bubble count resumes afterwards.
- PCSrcE=1 together with a load-use condition -> FlushD=FlushE=1, StallF=0; rst pulsed low mid MUL/DIV -> all outputs 0 immediately, MdBusy=0, no MdDone.
